iram_loader: RTL and testbench
==============================

Name: iram_loader

Overview:
- Serial-to-parallel program loader: the write side of the instruction RAM that the CPU reads through ADDR/Q.
- Accepts a byte stream over a valid/ready handshake and frames it into 16-bit instruction words.
- Issues one-cycle write strobes into the iram write port.
- Holds the CPU in reset (CPU_HOLD) until a complete, checksum-verified image is loaded.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
ADDR_W, 8, iram address width (matches 8-bit PC)
TIMEOUT, 1000, max idle cycles between bytes inside a frame; 0 disables the timeout

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
START  input  1  one-cycle pulse: begin/restart load
RX_DATA  input  8  incoming byte
RX_VALID  input  1  RX_DATA valid
RX_READY  output  1  loader can accept a byte
IADDR  output  ADDR_W  iram write address
IDATA  output  16  iram write data
IW  output  1  iram write strobe, one cycle per word
CPU_HOLD  output  1  1 = keep CPU in reset
BUSY  output  1  load in progress
DONE  output  1  last load succeeded (sticky until START)
ERR  output  1  last load failed (sticky until START)

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; RX_READY=0, IW=0, IADDR=0, IDATA=0, BUSY=0, DONE=0, ERR=0, CPU_HOLD=1, checksum=0, word count=0, timeout counter=0.
- Byte accepted only on a rising edge with RX_VALID=1 and RX_READY=1. RX_READY is 1 in SYNC, COUNT, HI, LO and CSUM, and 0 otherwise. The loader never stalls, so RX_READY is combinational from state.
- Frame format: SYNC_BYTE, N, then N words each sent hi byte then lo byte, then the checksum byte.
  - N=0 means 256 words.
  - Checksum = XOR of N and all data bytes.
- States:
  - IDLE: wait for START, then go to SYNC. On START: clear DONE/ERR, IADDR=0, checksum=0; set BUSY=1, CPU_HOLD=1.
  - SYNC: discard any byte other than SYNC_BYTE. On SYNC_BYTE go to COUNT. The timeout is not active in SYNC.
  - COUNT: latch N (0 becomes 256), checksum=N, go to HI.
  - HI: latch hi byte, XOR it into checksum, go to LO.
  - LO: on acceptance, in the next cycle drive IW=1, IDATA={hi,lo}, IADDR=current word index (IW latency = 1 cycle after the lo handshake). XOR the lo byte into checksum.
    - Remaining words after this one: go to HI.
    - This was word N: go to CSUM.
    - IADDR increments the cycle after IW and wraps 255 to 0.
  - CSUM: compare the received byte with the checksum.
    - Match: go to DONE_S.
    - Mismatch: go to ERR_S.
  - DONE_S: DONE=1, CPU_HOLD=0, BUSY=0, go to IDLE with outputs held.
  - ERR_S: ERR=1, CPU_HOLD stays 1, BUSY=0, go to IDLE.
- IW never asserts outside the cycle after a lo-byte acceptance. IDATA holds its last value when IW=0.
- Timeout: the counter clears on every accepted byte and runs in COUNT, HI, LO and CSUM. When it reaches TIMEOUT (TIMEOUT≠0), go to ERR_S. Words already written stay in iram.
- START in any non-IDLE state aborts the load. The next cycle is SYNC with IADDR=0, checksum=0, counter=0, DONE=ERR=0 and CPU_HOLD=1. A pending IW from the previous cycle still completes.
- START in the same cycle as a byte acceptance: START wins and the byte is dropped.
- START while DONE=1 reasserts CPU_HOLD immediately (next edge).
- RESET mid-load: everything returns to reset values and CPU_HOLD=1. Partial iram contents are not cleared.
- Word count uses a 9-bit counter, so N=256 writes addresses 0..255 exactly once.

Test Plan:
- Normal load: START, bytes A5,02,12,34,AB,CD,(02^12^34^AB^CD) -> IW twice: (0,16'h1234) then (1,16'hABCD), each 1 cycle after the lo handshake; DONE=1, CPU_HOLD=0, ERR=0.
- Sync hunt: START, bytes 00,FF,5A then a valid 1-word frame -> leading bytes ignored with no IW; the frame loads at IADDR 0 and DONE=1.
- Bad checksum: valid 1-word frame with checksum^8'h01 -> one IW issued, ERR=1, DONE=0, CPU_HOLD stays 1.
- N=0: 256 words, data = address -> 256 IW pulses covering IADDR 0..255, final IADDR wraps to 0, DONE=1.
- Abort and timeout: START mid-frame after 3 bytes -> back in SYNC with IADDR=0, then a full frame loads correctly. Separately, with TIMEOUT=8, stop RX_VALID after the hi byte -> ERR=1 after 8 idle cycles.
- Async reset: deassert RESET between clock edges mid-frame -> outputs go to reset values immediately (CPU_HOLD=1, RX_READY=0, IW=0), and a subsequent START plus frame succeeds.

Source files
------------

// File: rtl/iram_loader.sv
// rtl/iram_loader.sv - byte-stream program loader that frames 16-bit words into the iram write port
module iram_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 8,
  parameter int         TIMEOUT   = 1000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic [ADDR_W-1:0] IADDR,
  output logic [15:0]       IDATA,
  output logic              IW,
  output logic              CPU_HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  // Counter wide enough to hold TIMEOUT itself; one bit when the timeout is off.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    COUNT,
    HI,
    LO,
    CSUM,
    DONE_S,
    ERR_S
  } state_t;

  state_t        state;
  logic [7:0]    csum;
  logic [7:0]    hi_byte;
  logic [8:0]    n_words;
  logic [8:0]    word_cnt;
  logic [TW-1:0] tcnt;
  logic          acc;
  logic          in_frame;

  // The loader never back-pressures mid-state, so ready is a pure decode of the state.
  always_comb begin
    RX_READY = 1'b0;
    in_frame = 1'b0;
    case (state)
      SYNC:            RX_READY = 1'b1;
      COUNT, HI, LO, CSUM: begin
        RX_READY = 1'b1;
        in_frame = 1'b1;
      end
      default: begin
        RX_READY = 1'b0;
        in_frame = 1'b0;
      end
    endcase
  end

  assign acc = RX_VALID & RX_READY;

  // Frame sequencer: START always wins, then idle-timeout, then byte handling.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      IADDR    <= '0;
      IDATA    <= '0;
      IW       <= 1'b0;
      CPU_HOLD <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      csum     <= '0;
      hi_byte  <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      tcnt     <= '0;
    end else begin
      IW <= 1'b0;
      // Address advances the cycle after each write; 8-bit wrap is intended.
      if (IW) IADDR <= IADDR + ADDR_W'(1);
      if (START) begin
        state    <= SYNC;
        IADDR    <= '0;
        csum     <= '0;
        word_cnt <= '0;
        tcnt     <= '0;
        DONE     <= 1'b0;
        ERR      <= 1'b0;
        BUSY     <= 1'b1;
        CPU_HOLD <= 1'b1;
      end else if (in_frame && !acc) begin
        if (TIMEOUT != 0) begin
          tcnt <= tcnt + TW'(1);
          if (tcnt == TW'(TIMEOUT - 1)) state <= ERR_S;
        end
      end else begin
        if (acc) tcnt <= '0;
        case (state)
          SYNC: begin
            if (acc && RX_DATA == SYNC_BYTE) state <= COUNT;
          end
          COUNT: begin
            n_words  <= (RX_DATA == 8'h00) ? 9'd256 : {1'b0, RX_DATA};
            csum     <= RX_DATA;
            word_cnt <= '0;
            state    <= HI;
          end
          HI: begin
            hi_byte <= RX_DATA;
            csum    <= csum ^ RX_DATA;
            state   <= LO;
          end
          LO: begin
            IDATA    <= {hi_byte, RX_DATA};
            IW       <= 1'b1;
            csum     <= csum ^ RX_DATA;
            word_cnt <= word_cnt + 9'd1;
            state    <= (word_cnt + 9'd1 == n_words) ? CSUM : HI;
          end
          CSUM: begin
            state <= (RX_DATA == csum) ? DONE_S : ERR_S;
          end
          DONE_S: begin
            DONE     <= 1'b1;
            CPU_HOLD <= 1'b0;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end
          ERR_S: begin
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// tb/tb_iram_loader.sv - directed self-checking bench for iram_loader
module tb_iram_loader;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic [7:0]  IADDR;
  logic [15:0] IDATA;
  logic        IW;
  logic        CPU_HOLD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int compared   = 0;
  int mismatched = 0;
  int iw_cnt     = 0;
  int iw_base;

  iram_loader #(.SYNC_BYTE(8'hA5), .ADDR_W(8), .TIMEOUT(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RX_READY(RX_READY), .IADDR(IADDR), .IDATA(IDATA),
    .IW(IW), .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Count write strobes mid-cycle, away from the active edge.
  always @(negedge CLK) if (IW === 1'b1) iw_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    n = 0;
    while (RX_READY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("rx_ready_before_byte", {31'd0, RX_READY}, 32'd1);
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] addr);
    send(hi);
    send(lo);
    chk("iw_after_lo", {31'd0, IW}, 32'd1);
    chk("iaddr_at_iw", {24'd0, IADDR}, {24'd0, addr});
    chk("idata_at_iw", {16'd0, IDATA}, {16'd0, hi, lo});
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (DONE !== 1'b1 && ERR !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("load_finished_in_budget", {31'd0, (DONE === 1'b1 || ERR === 1'b1)}, 32'd1);
  endtask

  initial begin
    RESET    = 1'b0;
    START    = 1'b0;
    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_rx_ready", {31'd0, RX_READY}, 32'd0);
    chk("rst_iw",       {31'd0, IW}, 32'd0);
    chk("rst_iaddr",    {24'd0, IADDR}, 32'd0);
    chk("rst_idata",    {16'd0, IDATA}, 32'd0);
    chk("rst_busy",     {31'd0, BUSY}, 32'd0);
    chk("rst_done",     {31'd0, DONE}, 32'd0);
    chk("rst_err",      {31'd0, ERR}, 32'd0);
    chk("rst_cpu_hold", {31'd0, CPU_HOLD}, 32'd1);
    RESET = 1'b1;
    tick();

    // Normal 2-word load
    pulse_start();
    chk("start_busy",     {31'd0, BUSY}, 32'd1);
    chk("start_hold",     {31'd0, CPU_HOLD}, 32'd1);
    iw_base = iw_cnt;
    send(8'hA5);
    send(8'h02);
    send_word(8'h12, 8'h34, 8'd0);
    send_word(8'hAB, 8'hCD, 8'd1);
    send(8'h42);
    wait_end();
    chk("norm_done",  {31'd0, DONE}, 32'd1);
    chk("norm_err",   {31'd0, ERR}, 32'd0);
    chk("norm_hold",  {31'd0, CPU_HOLD}, 32'd0);
    chk("norm_busy",  {31'd0, BUSY}, 32'd0);
    chk("norm_iw_n",  iw_cnt - iw_base, 32'd2);
    chk("norm_iaddr", {24'd0, IADDR}, 32'd2);

    // START while DONE reasserts hold; then sync hunt
    pulse_start();
    chk("restart_hold", {31'd0, CPU_HOLD}, 32'd1);
    chk("restart_done", {31'd0, DONE}, 32'd0);
    chk("restart_iaddr", {24'd0, IADDR}, 32'd0);
    iw_base = iw_cnt;
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    chk("hunt_no_iw", iw_cnt - iw_base, 32'd0);
    send(8'hA5);
    send(8'h01);
    send_word(8'hDE, 8'hAD, 8'd0);
    send(8'h72);
    wait_end();
    chk("hunt_done", {31'd0, DONE}, 32'd1);
    chk("hunt_iw_n", iw_cnt - iw_base, 32'd1);

    // Bad checksum
    pulse_start();
    iw_base = iw_cnt;
    send(8'hA5);
    send(8'h01);
    send_word(8'h55, 8'hAA, 8'd0);
    send(8'hFF);
    wait_end();
    chk("bad_err",  {31'd0, ERR}, 32'd1);
    chk("bad_done", {31'd0, DONE}, 32'd0);
    chk("bad_hold", {31'd0, CPU_HOLD}, 32'd1);
    chk("bad_iw_n", iw_cnt - iw_base, 32'd1);

    // N=0 means 256 words, data equals address
    pulse_start();
    chk("n0_err_cleared", {31'd0, ERR}, 32'd0);
    iw_base = iw_cnt;
    send(8'hA5);
    send(8'h00);
    for (int i = 0; i < 256; i++) send_word(8'h00, 8'(i), 8'(i));
    send(8'h00);
    wait_end();
    chk("n0_done",  {31'd0, DONE}, 32'd1);
    chk("n0_iw_n",  iw_cnt - iw_base, 32'd256);
    chk("n0_iaddr", {24'd0, IADDR}, 32'd0);

    // Abort after 3 bytes, then a clean frame
    pulse_start();
    send(8'hA5);
    send(8'h02);
    send(8'h11);
    pulse_start();
    chk("abort_iaddr", {24'd0, IADDR}, 32'd0);
    chk("abort_ready", {31'd0, RX_READY}, 32'd1);
    chk("abort_busy",  {31'd0, BUSY}, 32'd1);
    send(8'hA5);
    send(8'h01);
    send_word(8'h12, 8'h34, 8'd0);
    send(8'h27);
    wait_end();
    chk("abort_done", {31'd0, DONE}, 32'd1);
    chk("abort_err",  {31'd0, ERR}, 32'd0);

    // Timeout after hi byte (TIMEOUT=8)
    pulse_start();
    send(8'hA5);
    send(8'h01);
    send(8'h77);
    repeat (6) tick();
    chk("to_not_yet", {31'd0, ERR}, 32'd0);
    wait_end();
    chk("to_err",  {31'd0, ERR}, 32'd1);
    chk("to_done", {31'd0, DONE}, 32'd0);
    chk("to_hold", {31'd0, CPU_HOLD}, 32'd1);

    // Asynchronous reset while a write strobe is high
    pulse_start();
    send(8'hA5);
    send(8'h02);
    send_word(8'h12, 8'h34, 8'd0);
    #1;
    RESET = 1'b0;
    #1;
    chk("arst_hold",  {31'd0, CPU_HOLD}, 32'd1);
    chk("arst_ready", {31'd0, RX_READY}, 32'd0);
    chk("arst_iw",    {31'd0, IW}, 32'd0);
    chk("arst_busy",  {31'd0, BUSY}, 32'd0);
    tick();
    RESET = 1'b1;
    tick();
    pulse_start();
    send(8'hA5);
    send(8'h01);
    send_word(8'h9C, 8'h3E, 8'd0);
    send(8'hA3);
    wait_end();
    chk("arst_reload_done", {31'd0, DONE}, 32'd1);
    chk("arst_reload_hold", {31'd0, CPU_HOLD}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
